interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Sequences entry into reset, NMI, IRQ and BRK service on the cpu6502 datapath. It detects and prioritises interrupt sources and waits for an instruction boundary. It then drives a fixed 5-step entry sequence:

- push PCH
- push PCL
- push P
- fetch vector low
- fetch vector high

It sits beside `control_unit`, which muxes these step requests onto bus selects and load strobes whenever `seq_active` is high.

## Interface
Parameters:
- `VEC_NMI`, default 8'hFA: vector low byte for NMI (high byte is always 8'hFF).
- `VEC_RESET`, default 8'hFC: vector low byte for reset.
- `VEC_IRQ`, default 8'hFE: vector low byte for IRQ and BRK.

Ports (clock and reset first). Clocking is decided: one clock; reset is synchronous and active-high.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `nmib` in 1: NMI request, active-low, falling-edge sensitive.
- `irqb` in 1: IRQ request, active-low, level sensitive.
- `flag_interrupt_disable` in 1: I flag from `status_register`.
- `instr_boundary` in 1: one-cycle pulse from `control_unit` on the cycle the next opcode would be fetched.
- `brk_request` in 1: pulse from `control_unit` when a BRK opcode has been decoded.
- `seq_active` out 1: the sequencer owns the datapath.
- `step` out 3: current step encoding (`interrupt_pkg::int_step_t`).
- `src` out 2: source being serviced (`interrupt_pkg::int_src_t`: Reset, Nmi, Brk, Irq).
- `write_en` out 1: current step writes memory. Follows the CtrlRead0Write1 convention (1 = write).
- `dec_sp` out 1: decrement the stack pointer after this step.
- `push_pch`, `push_pcl`, `push_p` out 1 each: data bus source requests.
- `load_pcl`, `load_pch` out 1 each: load PC byte from data_in on this step.
- `vector_low` out 8: address low byte for the VEC_LO/VEC_HI fetches. VEC_HI uses `vector_low + 1`.
- `break_flag` out 1: bit 4 value for the pushed P byte.
- `set_i` out 1: pulse to CtrlSetInterruptDisable.
- `done` out 1: one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI.
- Normal sequence runs IDLE → PUSH_PCH → … → VEC_HI → IDLE, one state per clock.
- NMI detect:
  - `nmib` is registered each cycle.
  - A 1→0 transition sets `nmi_pending`.
  - `nmi_pending` clears only in the PUSH_P step of an NMI-serviced sequence.
  - Holding `nmib` low does not retrigger.
- IRQ: `irq_req = !irqb && !flag_interrupt_disable`. It is sampled only at `instr_boundary` and is not latched.
- Start condition (IDLE only): `instr_boundary` with `nmi_pending` or `irq_req`, or `brk_request`.
- Start priority: Reset > Nmi > Brk > Irq.
- `brk_request` coinciding with a pending NMI: Nmi is serviced; BRK is not replayed.
- Reset sequence:
  - Entered on the first cycle after `reset` deasserts. It needs no boundary.
  - Push steps still assert `dec_sp` but force `write_en=0` (dummy reads).
- Per-step outputs:
  - PUSH_PCH / PUSH_PCL / PUSH_P: `write_en=1` (except Reset), `dec_sp=1`, and the matching `push_*`.
  - VEC_LO: `load_pcl`.
  - VEC_HI: `load_pch` and `set_i`.
- `break_flag=1` only when `src==Brk`; otherwise 0.
- `vector_low` follows `src`. It is registered at VEC_LO entry and stable through VEC_HI.
- `done` is asserted in the cycle after VEC_HI, together with the return to IDLE.
- Boundary cases:
  - `brk_request` or `instr_boundary` while not IDLE: ignored.
  - An NMI edge during an active sequence is latched as pending.
  - `reset` asserted mid-sequence: next state is IDLE. All pending state clears, and the Reset sequence starts after deassert.

## Timing
- Reset values:
  - `seq_active=0`, `step=IDLE`, `src=Reset`, `nmi_pending=0`.
  - All strobes 0, `vector_low=VEC_RESET`, `done=0`.
  - The registered `nmib` is reset to 1.
- Start latency:
  - Trigger cycle T; PUSH_PCH at T+1; VEC_HI at T+5; `done` at T+6.
  - `seq_active` is high T+1..T+5.
- NMI edge to pending: 1 cycle after `nmib` is sampled low.
- Back-to-back: with `done` at T+6, a new start can be accepted at T+6 if `instr_boundary` is presented then.

## Configuration
- `INT_NMI_HIJACK_EN` defined:
  - Applies while `src` is Brk or Irq and `step` is PUSH_PCH, PUSH_PCL or PUSH_P.
  - If `nmi_pending` is set in that window, `src` switches to Nmi before VEC_LO.
  - `nmi_pending` clears at VEC_LO; `vector_low=VEC_NMI`.
  - `break_flag` keeps the value already pushed.
- Undefined: `src` is fixed for the whole sequence, and the NMI stays pending for the next boundary.

## Structure
- `interrupt_pkg`: `int_step_t`, `int_src_t`, and the default vector constants. Shared with `control_unit`.
- Sub-module `nmi_edge_detect`: registered input, falling-edge pulse, and sticky pending bit with clear.

## Test plan
- Reset:
  - Stimulus: `reset` high for 3 cycles, then low.
  - Response: Reset steps with `write_en=0` all steps, `dec_sp` 3×, `vector_low=8'hFC`, `done` 6 cycles after deassert.
- IRQ:
  - Stimulus: `irqb=0`, I=0, `instr_boundary` pulse.
  - Response: Irq sequence, 3 writes, `break_flag=0`, `vector_low=8'hFE`, `set_i` at VEC_HI.
  - With I=1, the same stimulus gives no start.
- BRK vs NMI:
  - Stimulus: `brk_request` in the same cycle as a pending NMI.
  - Response: `src=Nmi`, `vector_low=8'hFA`, `break_flag=0`; the pending bit clears.
- NMI edge:
  - Stimulus: `nmib` held low for 20 cycles across two boundaries.
  - Response: exactly one Nmi sequence.
- Hijack (`INT_NMI_HIJACK_EN`):
  - Stimulus: NMI edge during PUSH_PCL of a BRK sequence.
  - Response: `break_flag=1` pushed, then `vector_low=8'hFA`.
  - Without the macro: `vector_low=8'hFE`, then an Nmi sequence at the next boundary.
- Mid-reset:
  - Stimulus: `reset` asserted at PUSH_P of an IRQ sequence.
  - Response: IDLE next cycle with no further writes, then a Reset sequence after deassert.

Source files
------------

// File: rtl/interrupt_pkg.sv
// interrupt_pkg: step and source encodings plus the default vector low bytes.
// Shared by interrupt_sequencer and control_unit.
package interrupt_pkg;

  typedef enum logic [2:0] {
    STEP_IDLE     = 3'd0,
    STEP_PUSH_PCH = 3'd1,
    STEP_PUSH_PCL = 3'd2,
    STEP_PUSH_P   = 3'd3,
    STEP_VEC_LO   = 3'd4,
    STEP_VEC_HI   = 3'd5
  } int_step_t;

  typedef enum logic [1:0] {
    SRC_RESET = 2'd0,
    SRC_NMI   = 2'd1,
    SRC_BRK   = 2'd2,
    SRC_IRQ   = 2'd3
  } int_src_t;

  localparam logic [7:0] VEC_NMI_DEF   = 8'hFA;
  localparam logic [7:0] VEC_RESET_DEF = 8'hFC;
  localparam logic [7:0] VEC_IRQ_DEF   = 8'hFE;

  // Vector low byte for a source; BRK shares the IRQ vector.
  function automatic logic [7:0] vec_for_src(input int_src_t s,
                                             input logic [7:0] v_nmi,
                                             input logic [7:0] v_reset,
                                             input logic [7:0] v_irq);
    case (s)
      SRC_RESET: return v_reset;
      SRC_NMI:   return v_nmi;
      default:   return v_irq;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_detect.sv
// nmi_edge_detect: registers nmib, flags a 1->0 transition and holds it as a
// sticky pending bit until the sequencer clears it. A new edge wins over a clear.
module nmi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_nmib,
  input  logic i_clr,
  output logic o_pending
);

  logic r_nmib_q;
  logic r_pending;
  logic w_fall;

  assign w_fall    = r_nmib_q & ~i_nmib;
  assign o_pending = r_pending;

  // Sample nmib and maintain the sticky pending bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nmib_q  <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_nmib_q <= i_nmib;
      if (w_fall)
        r_pending <= 1'b1;
      else if (i_clr)
        r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: prioritises reset/NMI/BRK/IRQ and drives the fixed
// 5-step entry sequence (push PCH, PCL, P, fetch vector low, vector high).
// Optional feature: INT_NMI_HIJACK_EN lets a pending NMI take over the vector
// fetch of a BRK/IRQ sequence that is still in its push steps.
//
// state    | meaning
// IDLE     | datapath owned by control_unit, waiting for a start condition
// PUSH_PCH | push PC high byte, SP--
// PUSH_PCL | push PC low byte, SP--
// PUSH_P   | push status byte, SP--
// VEC_LO   | load PCL from vector_low
// VEC_HI   | load PCH from vector_low+1, set I
import interrupt_pkg::*;

module interrupt_sequencer #(
  parameter logic [7:0] VEC_NMI   = VEC_NMI_DEF,
  parameter logic [7:0] VEC_RESET = VEC_RESET_DEF,
  parameter logic [7:0] VEC_IRQ   = VEC_IRQ_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nmib,
  input  logic       irqb,
  input  logic       flag_interrupt_disable,
  input  logic       instr_boundary,
  input  logic       brk_request,
  output logic       seq_active,
  output logic [2:0] step,
  output logic [1:0] src,
  output logic       write_en,
  output logic       dec_sp,
  output logic       push_pch,
  output logic       push_pcl,
  output logic       push_p,
  output logic       load_pcl,
  output logic       load_pch,
  output logic [7:0] vector_low,
  output logic       break_flag,
  output logic       set_i,
  output logic       done
);

  localparam logic [2:0] S_IDLE     = STEP_IDLE;
  localparam logic [2:0] S_PUSH_PCH = STEP_PUSH_PCH;
  localparam logic [2:0] S_PUSH_PCL = STEP_PUSH_PCL;
  localparam logic [2:0] S_PUSH_P   = STEP_PUSH_P;
  localparam logic [2:0] S_VEC_LO   = STEP_VEC_LO;
  localparam logic [2:0] S_VEC_HI   = STEP_VEC_HI;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  int_src_t   r_src;
  int_src_t   w_src_nxt;
  logic       r_reset_pend;
  logic       r_done;
  logic [7:0] r_vector_low;
  logic       w_nmi_pending;
  logic       w_nmi_clr;
  logic       w_irq_req;
  logic       w_push;
  logic       w_hijack_take;

  assign w_irq_req = !irqb && !flag_interrupt_disable;

  nmi_edge_detect u_nmi (
    .clk       (clk),
    .reset     (reset),
    .i_nmib    (nmib),
    .i_clr     (w_nmi_clr),
    .o_pending (w_nmi_pending)
  );

`ifdef INT_NMI_HIJACK_EN
  logic r_hijack;

  // A pending NMI is checked at the last push step so edges latched anywhere
  // in the push window are caught; src flips to Nmi on entry to VEC_LO.
  assign w_hijack_take = (r_state == S_PUSH_P) && w_nmi_pending &&
                         ((r_src == SRC_BRK) || (r_src == SRC_IRQ));
  assign w_nmi_clr     = ((r_state == S_PUSH_P) && (r_src == SRC_NMI)) ||
                         ((r_state == S_VEC_LO) && r_hijack);

  // Remember that the current VEC_LO step belongs to a hijacked sequence.
  always_ff @(posedge clk) begin
    if (reset)
      r_hijack <= 1'b0;
    else
      r_hijack <= w_hijack_take;
  end
`else
  assign w_hijack_take = 1'b0;
  assign w_nmi_clr     = (r_state == S_PUSH_P) && (r_src == SRC_NMI);
`endif

  // Next-state and source selection; starts are only taken from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    case (r_state)
      S_IDLE: begin
        if (r_reset_pend) begin
          w_state_nxt = S_PUSH_PCH;
          w_src_nxt   = SRC_RESET;
        end else if (w_nmi_pending && (instr_boundary || brk_request)) begin
          // A BRK decoded while an NMI is pending is absorbed, not replayed.
          w_state_nxt = S_PUSH_PCH;
          w_src_nxt   = SRC_NMI;
        end else if (brk_request) begin
          w_state_nxt = S_PUSH_PCH;
          w_src_nxt   = SRC_BRK;
        end else if (instr_boundary && w_irq_req) begin
          w_state_nxt = S_PUSH_PCH;
          w_src_nxt   = SRC_IRQ;
        end
      end
      S_PUSH_PCH: w_state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: w_state_nxt = S_PUSH_P;
      S_PUSH_P: begin
        w_state_nxt = S_VEC_LO;
        if (w_hijack_take)
          w_src_nxt = SRC_NMI;
      end
      S_VEC_LO:   w_state_nxt = S_VEC_HI;
      S_VEC_HI:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // State, source, vector and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src        <= SRC_RESET;
      r_reset_pend <= 1'b1;
      r_vector_low <= VEC_RESET;
      r_done       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_done  <= (r_state == S_VEC_HI);
      if ((r_state == S_IDLE) && r_reset_pend)
        r_reset_pend <= 1'b0;
      if (r_state == S_PUSH_P)
        r_vector_low <= vec_for_src(w_src_nxt, VEC_NMI, VEC_RESET, VEC_IRQ);
    end
  end

  assign w_push     = (r_state == S_PUSH_PCH) || (r_state == S_PUSH_PCL) ||
                      (r_state == S_PUSH_P);
  assign seq_active = (r_state != S_IDLE);
  assign step       = r_state;
  assign src        = r_src;
  // Reset entry performs dummy reads on the push steps.
  assign write_en   = w_push && (r_src != SRC_RESET);
  assign dec_sp     = w_push;
  assign push_pch   = (r_state == S_PUSH_PCH);
  assign push_pcl   = (r_state == S_PUSH_PCL);
  assign push_p     = (r_state == S_PUSH_P);
  assign load_pcl   = (r_state == S_VEC_LO);
  assign load_pch   = (r_state == S_VEC_HI);
  assign set_i      = (r_state == S_VEC_HI);
  assign vector_low = r_vector_low;
  assign break_flag = (r_src == SRC_BRK);
  assign done       = r_done;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed stimulus with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
import interrupt_pkg::*;

module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset, nmib, irqb, flag_interrupt_disable, instr_boundary, brk_request;
  logic       seq_active, write_en, dec_sp, push_pch, push_pcl, push_p;
  logic       load_pcl, load_pch, break_flag, set_i, done;
  logic [2:0] step;
  logic [1:0] src;
  logic [7:0] vector_low;
  logic [7:0] w_strb;
  int         n_chk = 0;
  int         n_err = 0;
  int         starts;

  interrupt_sequencer dut (
    .clk                    (clk),
    .reset                  (reset),
    .nmib                   (nmib),
    .irqb                   (irqb),
    .flag_interrupt_disable (flag_interrupt_disable),
    .instr_boundary         (instr_boundary),
    .brk_request            (brk_request),
    .seq_active             (seq_active),
    .step                   (step),
    .src                    (src),
    .write_en               (write_en),
    .dec_sp                 (dec_sp),
    .push_pch               (push_pch),
    .push_pcl               (push_pcl),
    .push_p                 (push_p),
    .load_pcl               (load_pcl),
    .load_pch               (load_pch),
    .vector_low             (vector_low),
    .break_flag             (break_flag),
    .set_i                  (set_i),
    .done                   (done)
  );

  always #5 clk = ~clk;

  assign w_strb = {write_en, dec_sp, push_pch, push_pcl, push_p, load_pcl, load_pch, set_i};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called in the PUSH_PCH cycle; walks the 5 steps and ends in the done cycle.
  // poke_kind 1: brk_request+instr_boundary at poke_step; 2: nmib falls there.
  task automatic seq_check(input string tag, input logic [1:0] s_push, input logic [1:0] s_vec,
                           input logic we, input logic [7:0] vec, input logic bf,
                           input int poke_step, input int poke_kind);
    logic [7:0] exp_s;
    for (int i = 1; i <= 5; i++) begin
      chk({tag, " step"}, step, i);
      chk({tag, " active"}, seq_active, 1);
      chk({tag, " src"}, src, (i <= 3) ? s_push : s_vec);
      case (i)
        1:       exp_s = {we, 7'b1100000};
        2:       exp_s = {we, 7'b1010000};
        3:       exp_s = {we, 7'b1001000};
        4:       exp_s = 8'b00000100;
        default: exp_s = 8'b00000011;
      endcase
      chk({tag, " strobes"}, w_strb, exp_s);
      if (i == 3) chk({tag, " break_flag"}, break_flag, bf);
      if (i >= 4) chk({tag, " vector_low"}, vector_low, vec);
      if (i == poke_step) begin
        if (poke_kind == 1) begin
          brk_request    = 1'b1;
          instr_boundary = 1'b1;
        end else begin
          nmib = 1'b0;
        end
      end
      tick;
      brk_request    = 1'b0;
      instr_boundary = 1'b0;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " idle"}, seq_active, 0);
    chk({tag, " step_idle"}, step, 0);
  endtask

  initial begin
    reset = 1'b1; nmib = 1'b1; irqb = 1'b1; flag_interrupt_disable = 1'b0;
    instr_boundary = 1'b0; brk_request = 1'b0;
    tick; tick; tick;
    chk("rst seq_active", seq_active, 0);
    chk("rst step", step, 0);
    chk("rst src", src, SRC_RESET);
    chk("rst strobes", w_strb, 0);
    chk("rst vector_low", vector_low, 8'hFC);
    chk("rst done", done, 0);

    // Reset sequence starts on the first cycle after deassert.
    reset = 1'b0;
    tick;
    seq_check("reset", SRC_RESET, SRC_RESET, 1'b0, 8'hFC, 1'b0, 0, 0);
    tick;
    chk("reset done_pulse", done, 0);

    // Masked IRQ gives no start.
    irqb = 1'b0; flag_interrupt_disable = 1'b1; instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    chk("irq_masked", seq_active, 0);

    // IRQ; a BRK/boundary during PUSH_PCL must be ignored.
    flag_interrupt_disable = 1'b0; instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0; irqb = 1'b1;
    seq_check("irq", SRC_IRQ, SRC_IRQ, 1'b1, 8'hFE, 1'b0, 2, 1);
    tick;
    chk("irq no_replay", seq_active, 0);

    // BRK, then an IRQ accepted in the done cycle.
    brk_request = 1'b1;
    tick;
    brk_request = 1'b0;
    seq_check("brk", SRC_BRK, SRC_BRK, 1'b1, 8'hFE, 1'b1, 0, 0);
    irqb = 1'b0; instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0; irqb = 1'b1;
    seq_check("b2b", SRC_IRQ, SRC_IRQ, 1'b1, 8'hFE, 1'b0, 0, 0);
    tick;

    // BRK coinciding with a pending NMI.
    nmib = 1'b0; tick; nmib = 1'b1; tick;
    brk_request = 1'b1;
    tick;
    brk_request = 1'b0;
    seq_check("brk_nmi", SRC_NMI, SRC_NMI, 1'b1, 8'hFA, 1'b0, 0, 0);
    tick;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    chk("brk_nmi cleared", seq_active, 0);

    // nmib held low for 20 cycles across two boundaries: one NMI only.
    starts = 0;
    nmib   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      instr_boundary = (i == 1) || (i == 12);
      tick;
      if (step == STEP_PUSH_PCH) begin
        starts++;
        chk("nmi_hold src", src, SRC_NMI);
      end
    end
    instr_boundary = 1'b0; nmib = 1'b1;
    chk("nmi_hold starts", starts, 1);
    tick;

    // NMI edge during PUSH_PCL of a BRK sequence.
    brk_request = 1'b1;
    tick;
    brk_request = 1'b0;
`ifdef INT_NMI_HIJACK_EN
    seq_check("hijack", SRC_BRK, SRC_NMI, 1'b1, 8'hFA, 1'b1, 2, 2);
    nmib = 1'b1;
    tick;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    chk("hijack no_replay", seq_active, 0);
`else
    seq_check("nohijack", SRC_BRK, SRC_BRK, 1'b1, 8'hFE, 1'b1, 2, 2);
    nmib = 1'b1;
    tick;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    seq_check("nmi_next", SRC_NMI, SRC_NMI, 1'b1, 8'hFA, 1'b0, 0, 0);
`endif
    tick;

    // Reset at PUSH_P of an IRQ sequence, with an NMI latched beforehand.
    irqb = 1'b0; instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0; irqb = 1'b1; nmib = 1'b0;
    tick;
    nmib = 1'b1;
    tick;
    chk("mid at_push_p", step, 3);
    reset = 1'b1;
    tick;
    chk("mid step", step, 0);
    chk("mid strobes", w_strb, 0);
    chk("mid done", done, 0);
    tick; tick;
    chk("mid hold", seq_active, 0);
    reset = 1'b0;
    tick;
    seq_check("mid_reset", SRC_RESET, SRC_RESET, 1'b0, 8'hFC, 1'b0, 0, 0);
    tick;
    instr_boundary = 1'b1;
    tick;
    instr_boundary = 1'b0;
    chk("mid pending_cleared", seq_active, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
